// File: rtl/procesador_pio_out_ctrl_if.sv
// Avalon-MM slave bus bundle for the output PIO controller.
// Ports: address[2:0], chipselect, read, write_n, writedata[31:0] (master -> slave),
//        readdata[31:0] (slave -> master, registered, valid one cycle after the read).
interface procesador_pio_out_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        read;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/procesador_pio_out_ctrl.sv
// Purpose: WIDTH-bit Avalon-MM output PIO with atomic SET/CLR/TOGGLE writes and an
//          optional pulse engine that inverts selected bits for PULSE_LEN cycles.
// Latency: register writes visible on out_port the edge after the write cycle;
//          readdata valid one cycle after chipselect&read. No backpressure (never stalls).
// Ports:   clk, reset (sync, active-high), avs (Avalon slave bus), out_port[WIDTH-1:0],
//          pulse_busy.
// Config:  define PIO_OUT_PULSE_EN to build the pulse engine (PLEN/PULSE/STATUS registers,
//          pulse_busy). Without it addresses 4..6 read 0, out_port = DATA, busy is tied 0.
module procesador_pio_out_ctrl #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int          CNT_W       = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    procesador_pio_out_ctrl_if.slave       avs,
    output logic [WIDTH-1:0]               out_port,
    output logic                           pulse_busy
);

    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_SET    = 3'd1;
    localparam logic [2:0] A_CLR    = 3'd2;
    localparam logic [2:0] A_TOGGLE = 3'd3;
    localparam logic [2:0] A_PLEN   = 3'd4;
    localparam logic [2:0] A_PULSE  = 3'd5;
    localparam logic [2:0] A_STATUS = 3'd6;

    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask;
    logic [31:0]      rd_mux;
    logic             unused_bits;

    assign wr = avs.chipselect & ~avs.write_n;
    assign rd = avs.chipselect & avs.read;
    assign wd = avs.writedata[WIDTH-1:0];

    // Upper writedata bits are only meaningful to PLEN/STATUS or not at all.
    assign unused_bits = ^avs.writedata;

    // DATA register and its atomic update aliases.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE[WIDTH-1:0];
        end else if (wr) begin
            case (avs.address)
                A_DATA:   data_q <= wd;
                A_SET:    data_q <= data_q | wd;
                A_CLR:    data_q <= data_q & ~wd;
                A_TOGGLE: data_q <= data_q ^ wd;
                default:  data_q <= data_q;
            endcase
        end
    end

`ifdef PIO_OUT_PULSE_EN
    localparam logic [0:0]       ST_IDLE   = 1'b0;
    localparam logic [0:0]       ST_ACTIVE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q;
    logic [CNT_W-1:0] plen_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mask_q;
    logic             ovr_q;
    logic             pulse_wr;
    logic             ovr_clr;

    // A zero-valued pulse write is a no-op in every state, including for overrun.
    assign pulse_wr = wr && (avs.address == A_PULSE) && (wd != '0);
    assign ovr_clr  = wr && (avs.address == A_STATUS) && avs.writedata[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            plen_q  <= CNT_ONE;
            cnt_q   <= '0;
            mask_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (wr && (avs.address == A_PLEN)) begin
                plen_q <= avs.writedata[CNT_W-1:0];
            end

            case (state_q)
                ST_IDLE: begin
                    if (pulse_wr) begin
                        state_q <= ST_ACTIVE;
                        mask_q  <= wd;
                        // Stored length 0 behaves as a single-cycle pulse.
                        cnt_q   <= (plen_q == '0) ? CNT_ONE : plen_q;
                    end
                end
                default: begin
                    cnt_q <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q <= ST_IDLE;
                        mask_q  <= '0;
                    end
                end
            endcase

            // Sticky overrun: a retrigger on the same edge as a clear wins.
            if (pulse_wr && (state_q == ST_ACTIVE)) begin
                ovr_q <= 1'b1;
            end else if (ovr_clr) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign mask       = mask_q;
    assign pulse_busy = (state_q == ST_ACTIVE);
`else
    assign mask       = '0;
    assign pulse_busy = 1'b0;
`endif

    // Read mux; write-only aliases and the reserved slot read as zero.
    always_comb begin
        rd_mux = '0;
        case (avs.address)
            A_DATA:   rd_mux[WIDTH-1:0] = data_q;
`ifdef PIO_OUT_PULSE_EN
            A_PLEN:   rd_mux[CNT_W-1:0] = plen_q;
            A_PULSE:  rd_mux[WIDTH-1:0] = mask_q;
            A_STATUS: rd_mux[1:0]       = {ovr_q, pulse_busy};
`endif
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs.readdata <= '0;
        end else if (rd) begin
            avs.readdata <= rd_mux;
        end else begin
            avs.readdata <= '0;
        end
    end

    assign out_port = data_q ^ mask;

endmodule
